// File: rtl/hex_word_streamer.sv
// Streams a DATA_W-bit word as 16-bit hex character codes, MSB digit first,
// with valid/ready on both sides and optional leading-zero blanking.
module hex_word_streamer #(
  parameter int          DATA_W     = 32,
  parameter logic [7:0]  ATTR       = 8'hFF,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              lz_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_code,
  output logic              out_last,
  output logic              busy
);

  localparam int NDIG = DATA_W / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lz_q, lz_d;
  logic              zr_q, zr_d;

  logic [3:0] dig;
  logic [7:0] chr;
  logic       send;
  logic       blank;

  assign dig  = sh_q[DATA_W-1 -: 4];
  assign send = (state_q == SEND);

  always_comb begin
    chr = 8'h30 + {4'h0, dig};
    if (dig > 4'd9) begin
      chr = 8'h37 + {4'h0, dig};
    end
  end

  // The last digit is never blanked so an all-zero word still shows "0".
  assign blank = lz_q && zr_q && (dig == 4'h0) && (cnt_q != '0);

  assign load_ready = !send;
  assign out_valid  = send;
  assign busy       = send;
  assign out_last   = send && (cnt_q == '0);
  assign out_code   = send ? {ATTR, (blank ? BLANK_CHAR : chr)} : 16'h0000;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    lz_d    = lz_q;
    zr_d    = zr_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          sh_d    = load_data;
          cnt_d   = CW'(NDIG - 1);
          lz_d    = lz_mode;
          zr_d    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          sh_d  = sh_q << 4;
          cnt_d = cnt_q - CW'(1);
          zr_d  = zr_q && (dig == 4'h0);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      lz_q    <= 1'b0;
      zr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      lz_q    <= lz_d;
      zr_q    <= zr_d;
    end
  end

endmodule

// File: tb/tb_hex_word_streamer.sv
// Scoreboard bench for hex_word_streamer: 32-, 8- and 4-bit instances.
// Expected codes are queued at load time and popped on output handshakes.
module tb_hex_word_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Independent model: digit i (0 = MSB) of an nd-digit word.
  function automatic logic [16:0] exp_dig(input logic [31:0] w, input int nd,
                                          input logic lz, input int i);
    string      hx = "0123456789ABCDEF";
    logic [3:0] d;
    logic       zeros = 1'b1;
    logic [7:0] c;
    for (int j = 0; j < i; j++) begin
      if (((w >> (4 * (nd - 1 - j))) & 32'hF) != 0) zeros = 1'b0;
    end
    d = 4'((w >> (4 * (nd - 1 - i))) & 32'hF);
    c = hx[d];
    if (lz && zeros && d == 4'h0 && i != nd - 1) c = 8'h20;
    return {(i == nd - 1), 8'hFF, c};
  endfunction

  // 32-bit instance
  logic        lv_a = 1'b0, lr_a, lz_a = 1'b0, ov_a, or_a = 1'b0, last_a, busy_a;
  logic [31:0] ld_a = '0;
  logic [15:0] code_a;
  logic [16:0] q_a[$];

  hex_word_streamer #(.DATA_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .load_valid(lv_a), .load_ready(lr_a), .load_data(ld_a),
    .lz_mode(lz_a), .out_valid(ov_a), .out_ready(or_a),
    .out_code(code_a), .out_last(last_a), .busy(busy_a)
  );

  // 8-bit instance
  logic        lv_b = 1'b0, lr_b, ov_b, or_b = 1'b0, last_b, busy_b;
  logic [7:0]  ld_b = '0;
  logic [15:0] code_b;
  logic [16:0] q_b[$];

  hex_word_streamer #(.DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .load_valid(lv_b), .load_ready(lr_b), .load_data(ld_b),
    .lz_mode(1'b0), .out_valid(ov_b), .out_ready(or_b),
    .out_code(code_b), .out_last(last_b), .busy(busy_b)
  );

  // 4-bit instance
  logic        lv_c = 1'b0, lr_c, ov_c, or_c = 1'b0, last_c, busy_c;
  logic [3:0]  ld_c = '0;
  logic [15:0] code_c;
  logic [16:0] q_c[$];

  hex_word_streamer #(.DATA_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .load_valid(lv_c), .load_ready(lr_c), .load_data(ld_c),
    .lz_mode(1'b1), .out_valid(ov_c), .out_ready(or_c),
    .out_code(code_c), .out_last(last_c), .busy(busy_c)
  );

  always @(negedge clk) begin
    if (rst_n && ov_a && or_a) begin
      if (q_a.size() == 0) chk("a_extra", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q_a.pop_front();
        chk("a_code", {16'h0, code_a}, {16'h0, e[15:0]});
        chk("a_last", {31'h0, last_a}, {31'h0, e[16]});
      end
    end
    if (rst_n && ov_b && or_b) begin
      if (q_b.size() == 0) chk("b_extra", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q_b.pop_front();
        chk("b_code", {16'h0, code_b}, {16'h0, e[15:0]});
        chk("b_last", {31'h0, last_b}, {31'h0, e[16]});
      end
    end
    if (rst_n && ov_c && or_c) begin
      if (q_c.size() == 0) chk("c_extra", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q_c.pop_front();
        chk("c_code", {16'h0, code_c}, {16'h0, e[15:0]});
        chk("c_last", {31'h0, last_c}, {31'h0, e[16]});
      end
    end
  end

  // Returns one tick after the acceptance edge with load_valid dropped.
  task automatic start_word(input logic [31:0] w, input logic lz);
    @(posedge clk);
    #1;
    lv_a = 1'b1;
    ld_a = w;
    lz_a = lz;
    for (int i = 0; i < 8; i++) q_a.push_back(exp_dig(w, 8, lz, i));
    @(negedge clk);
    chk("load_ready_idle", {31'h0, lr_a}, 32'd1);
    @(posedge clk);
    #1;
    lv_a = 1'b0;
  endtask

  task automatic run_word(input logic [31:0] w, input logic lz);
    or_a = 1'b1;
    start_word(w, lz);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'h0, ov_a}, 32'd1);
    end
    @(negedge clk);
    chk("ready_back", {31'h0, lr_a}, 32'd1);
    chk("valid_drop", {31'h0, ov_a}, 32'd0);
    chk("sb_drain", q_a.size(), 32'd0);
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (lr_a && q_a.size() == 0) done = 1'b1;
    end
    chk("idle_timeout", {31'h0, done}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'h0, ov_a}, 32'd0);
    chk("rst_ready", {31'h0, lr_a}, 32'd1);
    chk("rst_code", {16'h0, code_a}, 32'h0);
    chk("rst_last", {31'h0, last_a}, 32'd0);
    chk("rst_busy", {31'h0, busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_word(32'h00403A1F, 1'b0);
    run_word(32'h00403A1F, 1'b1);
    run_word(32'h00000000, 1'b1);
    run_word(32'hFEDCBA98, 1'b1);

    // Backpressure while FF33 is presented
    or_a = 1'b1;
    start_word(32'h12345678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    or_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, ov_a}, 32'd1);
      chk("bp_hold", {16'h0, code_a}, 32'h0000FF33);
      @(posedge clk);
      #1;
    end
    or_a = 1'b1;
    wait_idle();

    // Load request while busy is ignored
    start_word(32'h0BADF00D, 1'b1);
    lv_a = 1'b1;
    ld_a = 32'hFFFFFFFF;
    lz_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("busy_ld_rdy", {31'h0, lr_a}, 32'd0);
      chk("busy_flag", {31'h0, busy_a}, 32'd1);
    end
    @(posedge clk);
    #1;
    lv_a = 1'b0;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("no_reload", {31'h0, ov_a}, 32'd0);
    end

    // Asynchronous reset after the third digit
    start_word(32'h12345678, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, ov_a}, 32'd0);
    chk("arst_busy", {31'h0, busy_a}, 32'd0);
    chk("arst_ready", {31'h0, lr_a}, 32'd1);
    chk("arst_code", {16'h0, code_a}, 32'h0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_word(32'h0000000A, 1'b0);

    // Narrow instances
    @(posedge clk);
    #1;
    or_b = 1'b1;
    or_c = 1'b1;
    lv_b = 1'b1;
    ld_b = 8'hF9;
    lv_c = 1'b1;
    ld_c = 4'hC;
    for (int i = 0; i < 2; i++) q_b.push_back(exp_dig(32'hF9, 2, 1'b0, i));
    q_c.push_back(exp_dig(32'hC, 1, 1'b1, 0));
    @(posedge clk);
    #1;
    lv_b = 1'b0;
    lv_c = 1'b0;
    @(negedge clk);
    chk("c_single_last", {31'h0, last_c}, 32'd1);
    repeat (3) @(negedge clk);
    chk("b_drain", q_b.size(), 32'd0);
    chk("c_drain", q_c.size(), 32'd0);
    chk("b_idle", {31'h0, lr_b}, 32'd1);
    chk("c_idle", {31'h0, lr_c}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
